// File: rtl/pool_stream_unit_if.sv
// rtl/pool_stream_unit_if.sv - stream handshake bundle for the pooling engine
interface pool_stream_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4
);
  logic                     mode;
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;

  modport master (
    output mode, flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  mode, flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pool_stream_unit.sv
// rtl/pool_stream_unit.sv - multi-lane streaming max/floor-average pooling engine
module pool_stream_unit #(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 4,
  parameter int WIN_SIZE = 4,
  parameter int CNT_W    = $clog2(WIN_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  pool_stream_if.slave  s
);
  localparam int ACC_W = DATA_W + CNT_W;

  typedef enum logic {ST_COLLECT, ST_OUTPUT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     mode_q, mode_d;
  logic [NUM_CH*DATA_W-1:0] out_data_q, out_data_d;
  logic signed [ACC_W-1:0]  acc_q    [NUM_CH];
  logic signed [ACC_W-1:0]  acc_d    [NUM_CH];
  logic signed [ACC_W-1:0]  acc_new  [NUM_CH];
  logic signed [ACC_W-1:0]  elem_ext [NUM_CH];

  logic out_valid, out_fire, accept, first, last, eff_mode;

  assign out_valid   = (state_q == ST_OUTPUT);
  assign s.out_valid = out_valid;
  assign s.out_data  = out_data_q;
  assign s.in_ready  = !out_valid || s.out_ready;

  assign out_fire = out_valid && s.out_ready;
  assign accept   = s.in_valid && s.in_ready && !s.flush;
  assign first    = (cnt_q == '0);
  assign last     = accept && (cnt_q == CNT_W'(WIN_SIZE - 1));
  // The first beat of a window uses the live mode; later beats use the latched copy.
  assign eff_mode = first ? s.mode : mode_q;

  always_comb begin
    out_data_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      elem_ext[c] = {{CNT_W{s.in_data[c*DATA_W + DATA_W - 1]}}, s.in_data[c*DATA_W +: DATA_W]};
      if (first)
        acc_new[c] = elem_ext[c];
      else if (eff_mode)
        acc_new[c] = acc_q[c] + elem_ext[c];
      else
        acc_new[c] = (elem_ext[c] > acc_q[c]) ? elem_ext[c] : acc_q[c];
      // Taking the upper DATA_W bits is the arithmetic shift by CNT_W (floor division).
      out_data_d[c*DATA_W +: DATA_W] = eff_mode ? acc_new[c][CNT_W +: DATA_W]
                                                : acc_new[c][DATA_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    case (state_q)
      ST_COLLECT: if (last) state_d = ST_OUTPUT;
      ST_OUTPUT:  if (out_fire && !last) state_d = ST_COLLECT;
      default:    state_d = ST_COLLECT;
    endcase
    if (s.flush) begin
      cnt_d = '0;
      for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
    end else if (accept) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      if (first) mode_d = s.mode;
      acc_d = acc_new;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_COLLECT;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      if (last) out_data_q <= out_data_d;
    end
  end
endmodule

// File: tb/tb_pool_stream_unit.sv
// tb/tb_pool_stream_unit.sv - self-checking bench for pool_stream_unit
module tb_pool_stream_unit;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 4;
  localparam int WIN    = 4;
  localparam int BUS_W  = NUM_CH * DATA_W;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pool_stream_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  pool_stream_unit #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .WIN_SIZE(WIN)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: raw window elements, floor/max computed with integers.
  int             md_el [NUM_CH][WIN];
  int             md_cnt;
  bit             md_mode;
  bit             md_pend;
  bit             md_last_acc;
  logic [BUS_W-1:0] md_exp;

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int floor_div(input int s);
    return (s >= 0) ? s / WIN : -((-s + WIN - 1) / WIN);
  endfunction

  function automatic logic [BUS_W-1:0] pool_ref();
    logic [BUS_W-1:0] r;
    int sum, mx, v;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sum = 0;
      mx  = md_el[c][0];
      for (int k = 0; k < WIN; k++) begin
        sum += md_el[c][k];
        if (md_el[c][k] > mx) mx = md_el[c][k];
      end
      v = md_mode ? floor_div(sum) : mx;
      r[c*DATA_W +: DATA_W] = 16'(v);
    end
    return r;
  endfunction

  task automatic model_reset();
    md_cnt  = 0;
    md_mode = 1'b0;
    md_pend = 1'b0;
    md_exp  = '0;
  endtask

  task automatic model_edge(input bit v, input logic [BUS_W-1:0] d, input bit m, input bit f, input bit ordy);
    bit rdy, acc;
    rdy = !md_pend || ordy;
    acc = v && rdy && !f;
    md_last_acc = acc;
    if (md_pend && ordy) md_pend = 1'b0;
    if (f) begin
      md_cnt = 0;
    end else if (acc) begin
      if (md_cnt == 0) md_mode = m;
      for (int c = 0; c < NUM_CH; c++) md_el[c][md_cnt] = int'($signed(d[c*DATA_W +: DATA_W]));
      md_cnt++;
      if (md_cnt == WIN) begin
        md_exp  = pool_ref();
        md_pend = 1'b1;
        md_cnt  = 0;
      end
    end
  endtask

  // Called at a negedge: drive, check ready, advance model over the posedge, check outputs.
  task automatic cycle(input bit v, input logic [BUS_W-1:0] d, input bit m, input bit f, input bit ordy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.mode      = m;
    bus.flush     = f;
    bus.out_ready = ordy;
    #1;
    chk("in_ready", BUS_W'(bus.in_ready), BUS_W'(!md_pend || ordy));
    model_edge(v, d, m, f, ordy);
    @(negedge clk);
    chk("out_valid", BUS_W'(bus.out_valid), BUS_W'(md_pend));
    if (md_pend) chk("out_data", bus.out_data, md_exp);
  endtask

  task automatic send_beat(input logic [BUS_W-1:0] d, input bit m, input bit ordy);
    for (int t = 0; t < 64; t++) begin
      cycle(1'b1, d, m, 1'b0, ordy);
      if (md_last_acc) return;
    end
    checks++;
    errors++;
    $display("FAIL send_beat_timeout actual=not_accepted required=accepted");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.mode = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_out_valid", BUS_W'(bus.out_valid), '0);
    chk("reset_out_data", bus.out_data, '0);
    chk("reset_in_ready", BUS_W'(bus.in_ready), BUS_W'(1));
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [BUS_W-1:0] rep(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  typedef struct packed {
    logic            mode;
    logic [0:3][15:0] l0;
    logic [0:3][15:0] l1;
    logic [15:0]     e0;
    logic [15:0]     e1;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [BUS_W-1:0] d, hd;
    bit hv, rf, rm, ro;
    int nvalid;
    checks = 0;
    errors = 0;

    vt[0] = '{1'b0, {16'h0800, 16'h0C00, 16'hFC00, 16'hF000}, {16'h0, 16'h0, 16'h0, 16'h0}, 16'h0C00, 16'h0000};
    vt[1] = '{1'b1, {16'h5000, 16'h5800, 16'h6000, 16'h6800}, {16'hB000, 16'hA800, 16'hA000, 16'h9800}, 16'h5C00, 16'hA400};
    vt[2] = '{1'b0, {16'h5000, 16'h5800, 16'h6000, 16'h6800}, {16'hB000, 16'hA800, 16'hA000, 16'h9800}, 16'h6800, 16'hB000};
    vt[3] = '{1'b1, {16'h0001, 16'h0, 16'h0, 16'h0}, {16'hFFFF, 16'h0, 16'h0, 16'h0}, 16'h0000, 16'hFFFF};
    vt[4] = '{1'b1, {16'h0800, 16'h0C00, 16'hFC00, 16'hF000}, {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 16'h0000, 16'h8000};
    vt[5] = '{1'b1, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, {16'h8000, 16'h7FFF, 16'h0, 16'h0}, 16'h7FFF, 16'hFFFF};

    do_reset();

    // Table windows, back to back, out_ready held high.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < WIN; k++) begin
        d = {16'h0, 16'h0, vt[i].l1[k], vt[i].l0[k]};
        cycle(1'b1, d, vt[i].mode, 1'b0, 1'b1);
      end
      chk($sformatf("vec%0d_valid", i), BUS_W'(bus.out_valid), BUS_W'(1));
      chk($sformatf("vec%0d_lane0", i), BUS_W'(bus.out_data[15:0]), BUS_W'(vt[i].e0));
      chk($sformatf("vec%0d_lane1", i), BUS_W'(bus.out_data[31:16]), BUS_W'(vt[i].e1));
    end
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("table_drain_valid", BUS_W'(bus.out_valid), '0);

    // Backpressure: first result held while the next window waits.
    send_beat(rep(16'h0100), 1'b0, 1'b0);
    send_beat(rep(16'h0200), 1'b0, 1'b0);
    send_beat(rep(16'h0300), 1'b0, 1'b0);
    send_beat(rep(16'h0050), 1'b0, 1'b0);
    chk("bp_first", bus.out_data, rep(16'h0300));
    repeat (3) cycle(1'b1, rep(16'h0010), 1'b1, 1'b0, 1'b0);
    chk("bp_in_ready_low", BUS_W'(bus.in_ready), '0);
    chk("bp_stable", bus.out_data, rep(16'h0300));
    send_beat(rep(16'h0010), 1'b1, 1'b1);
    send_beat(rep(16'h0020), 1'b1, 1'b1);
    send_beat(rep(16'h0030), 1'b1, 1'b1);
    send_beat(rep(16'h0040), 1'b1, 1'b1);
    chk("bp_second", bus.out_data, rep(16'h0028));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("bp_no_dup", BUS_W'(bus.out_valid), '0);

    // Throughput: three windows in twelve cycles, one result per window.
    nvalid = 0;
    for (int k = 0; k < 3 * WIN; k++) begin
      cycle(1'b1, rep(16'(k * 16'h0100)), 1'b1, 1'b0, 1'b1);
      if (bus.out_valid) nvalid++;
    end
    chk("throughput_results", BUS_W'(nvalid), BUS_W'(3));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Mode latched on the first beat.
    send_beat(rep(16'h0100), 1'b0, 1'b1);
    send_beat(rep(16'h0400), 1'b0, 1'b1);
    send_beat(rep(16'h0200), 1'b1, 1'b1);
    send_beat(rep(16'h0300), 1'b1, 1'b1);
    chk("mode_latch_max", bus.out_data, rep(16'h0400));
    send_beat(rep(16'h0100), 1'b1, 1'b1);
    send_beat(rep(16'h0400), 1'b1, 1'b1);
    send_beat(rep(16'h0200), 1'b0, 1'b1);
    send_beat(rep(16'h0300), 1'b0, 1'b1);
    chk("mode_latch_avg", bus.out_data, rep(16'h0280));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Flush drops the partial window and the coincident beat.
    for (int k = 0; k < 3; k++) send_beat(rep(16'h7000), 1'b0, 1'b1);
    cycle(1'b1, rep(16'h7000), 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < WIN; k++) send_beat(rep(16'h0400), 1'b1, 1'b1);
    chk("flush_result", bus.out_data, rep(16'h0400));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Async reset mid-window, then while a result is pending.
    send_beat(rep(16'h1234), 1'b0, 1'b1);
    send_beat(rep(16'h2345), 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_mid_valid", BUS_W'(bus.out_valid), '0);
    chk("arst_mid_data", bus.out_data, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < WIN; k++) send_beat(rep(16'(16'h0111 * (k + 1))), 1'b0, 1'b0);
    chk("arst_pend_before", bus.out_data, rep(16'h0444));
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", BUS_W'(bus.out_valid), '0);
    chk("arst_out_data", bus.out_data, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < WIN; k++) send_beat(rep(16'hFFF0 + 16'(k)), 1'b1, 1'b1);
    chk("arst_recover", bus.out_data, rep(16'hFFF1));

    // Randomized traffic against the model.
    hv = 1'b0;
    hd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < NUM_CH; c++) begin
          case ($urandom_range(0, 7))
            0:       hd[c*DATA_W +: DATA_W] = 16'h8000;
            1:       hd[c*DATA_W +: DATA_W] = 16'h7FFF;
            default: hd[c*DATA_W +: DATA_W] = 16'($urandom);
          endcase
        end
      end
      rf = ($urandom_range(0, 15) == 0);
      rm = 1'($urandom);
      ro = ($urandom_range(0, 3) != 0);
      cycle(hv, hd, rm, rf, ro);
      if (md_last_acc || rf) hv = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
